ram_be_pipe: RTL and testbench
==============================

// Module: ram_be_pipe
// PURPOSE
//   Parametrised simple dual-port RAM: one write port with byte enables, one read port with valid.
//   Read latency is 1 or 2 cycles, selectable read-during-write bypass, and an optional
//   post-reset clear sequencer. General storage for aligner and command buffers.
//   Next generation of the plain registered-read RAM. Keeps big-endian bit ordering [0:N-1].
// PARAMETERS
//   RAM_OPT     "m20k,no_rw_check"  ramstyle attribute, applied only under `use_altera_atts
//   WIDTH       64                  data width in bits; must be a multiple of 8 (elaboration error otherwise)
//   DEPTH       32                  number of words; need not be a power of 2
//   ADDR_BITS   $clog2(DEPTH)       address width
//   BE_BITS     WIDTH/8             byte-enable width; wbe[i] covers d[8*i : 8*i+7] (byte 0 = MSBs)
//   RD_LATENCY  1                   cycles from re to q_valid; 1 or 2 only (elaboration error otherwise)
//   RW_BYPASS   1                   1: read of the address being written returns new data; 0: returns old data
//   INIT_CLEAR  1                   1: zero the whole array after reset; 0: no clear, ready at reset release
// PORTS
//   clk        in   1          rising-edge clock
//   rst_n      in   1          asynchronous, active-low reset
//   init_busy  out  1          high while the clear sweep runs; all accesses are ignored
//   wrad       in   ADDR_BITS  write address [0:ADDR_BITS-1]
//   we         in   1          write strobe
//   wbe        in   BE_BITS    byte enables [0:BE_BITS-1]
//   d          in   WIDTH      write data [0:WIDTH-1]
//   rdad       in   ADDR_BITS  read address
//   re         in   1          read strobe
//   q          out  WIDTH      read data; holds its value between reads
//   q_valid    out  1          one-cycle pulse, RD_LATENCY cycles after an accepted re
// BEHAVIOUR
//   Reset (async assert): q=0, q_valid=0, all pipeline stages and valids = 0, clear counter = 0.
//     init_busy = INIT_CLEAR. The memory array itself is not reset.
//   FSM (INIT_CLEAR=1): CLEAR -> READY. In CLEAR, write zero to memory[cnt] each cycle; cnt runs 0..DEPTH-1.
//     Go to READY after cnt = DEPTH-1, so init_busy is high for exactly DEPTH cycles after rst_n rises.
//     READY is terminal until the next reset. rst_n low mid-sweep restarts the sweep at 0.
//     With INIT_CLEAR=0 the FSM is tied to READY.
//   Accepted write: we & ~init_busy & (wrad < DEPTH). For every i with wbe[i]=1, byte i of memory[wrad]
//     takes byte i of d. Other bytes are unchanged. wbe = 0 is a legal no-op.
//   Accepted read: re & ~init_busy. Stage 1 registers memory[rdad].
//     rdad >= DEPTH reads all zeros; q_valid still pulses.
//   Collision (accepted write and read, wrad == rdad, same cycle):
//     RW_BYPASS=1 -> stage 1 gets the merged word: enabled bytes from d, the rest from the old word.
//     RW_BYPASS=0 -> stage 1 gets the old word.
//   RD_LATENCY=1: q = stage 1, q_valid = registered accept.
//   RD_LATENCY=2: stage 2 loads stage 1 when stage-1 valid is set.
//     q = stage 2; q_valid is delayed one more cycle.
//   Pipeline is fully pipelined: back-to-back reads give back-to-back q_valid with data in issue order.
//   q updates only on q_valid and otherwise holds. re/we ignored during init produce no q_valid and no write.
// STRUCTURE
//   Shared package ram_pkg:
//     BYTE_W = 8; RD_LAT_MIN = 1; RD_LAT_MAX = 2;
//     FSM state encodings INIT_CLEAR_S = 1'b0, INIT_READY_S = 1'b1;
//     byte-merge function be_merge(old, new, be).
//   Sub-module ram_init_seq: clear FSM plus counter. Outputs init_busy, clr_we, clr_ad.
//     Top-level write mux selects the clear write over the user write while busy.
//   Memory array, bypass merge and read pipeline stay in ram_be_pipe.
// TESTING (WIDTH=64, DEPTH=32 unless noted)
//   1 Init: release rst_n -> init_busy=1 for exactly 32 cycles.
//     Then re on addresses 0..31 -> each q=64'h0, q_valid pulses 32 times.
//   2 Byte enables: write addr 5 d=64'h0011223344556677 wbe=8'hFF; then write addr 5 d=64'hAAAAAAAAAAAAAAAA wbe=8'h80.
//     re addr 5 -> q=64'hAA11223344556677 one cycle later.
//   3 Collision: addr 3 holds 0; same cycle we addr 3 d=64'h1234567890ABCDEF wbe=8'h0F, re addr 3.
//     RW_BYPASS=1 -> q=64'h0000000090ABCDEF. RW_BYPASS=0 -> q=0.
//   4 RD_LATENCY=2: re on addresses 0,1,2,3 in consecutive cycles (each preloaded with its own index).
//     q_valid high in cycles +2..+5, q = 0,1,2,3 in order; q holds 3 afterwards.
//   5 Reset mid-clear: drop rst_n at cycle 10 of the sweep -> q_valid=0 immediately;
//     after release init_busy is high for 32 more cycles.
//     we addr 31 d=all-ones issued during the sweep -> read of 31 returns 0.
//   6 DEPTH=24: we addr 30 -> no effect; re addr 30 -> q=0 with q_valid=1; addr 23 read/write works normally.

Source files
------------

// File: rtl/ram_pkg.sv
// ram_pkg: shared constants, clear-FSM state encoding and the byte-lane merge helper
// used by the byte-enable RAM family (ram_be_pipe and its clear sequencer).
package ram_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 2;

  typedef enum logic {
    INIT_CLEAR_S = 1'b0,
    INIT_READY_S = 1'b1
  } init_state_e;

  // One byte lane of a byte-enabled write: the new byte when enabled, else the old one.
  function automatic logic [0:BYTE_W-1] be_merge(input logic [0:BYTE_W-1] old_byte,
                                                 input logic [0:BYTE_W-1] new_byte,
                                                 input logic              be);
    return be ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/ram_init_seq.sv
// ram_init_seq: post-reset clear sequencer. Sweeps a write of zero over addresses
// 0..DEPTH-1, one per cycle, then parks in READY until the next reset.
// Ports:
//   i_clk        rising-edge clock
//   i_rst_n      asynchronous active-low reset; restarts the sweep at address 0
//   o_init_busy  high while the sweep runs
//   o_clr_we     clear write strobe (valid while busy)
//   o_clr_ad     clear write address
module ram_init_seq
  import ram_pkg::*;
#(
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned ADDR_BITS  = $clog2(DEPTH),
  parameter int unsigned INIT_CLEAR = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  output logic                 o_init_busy,
  output logic                 o_clr_we,
  output logic [0:ADDR_BITS-1] o_clr_ad
);

  localparam logic [0:ADDR_BITS-1] LAST_AD = ADDR_BITS'(DEPTH - 1);

  init_state_e            r_state;
  init_state_e            w_state_d;
  logic [0:ADDR_BITS-1]   r_cnt;
  logic [0:ADDR_BITS-1]   w_cnt_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      if (INIT_CLEAR != 0) r_state <= INIT_CLEAR_S;
      else                 r_state <= INIT_READY_S;
      r_cnt <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    o_clr_we  = 1'b0;
    unique case (r_state)
      INIT_CLEAR_S: begin
        o_clr_we = 1'b1;
        w_cnt_d  = r_cnt + 1'b1;
        if (r_cnt == LAST_AD) w_state_d = INIT_READY_S;
      end
      INIT_READY_S: ;
      default: w_state_d = INIT_READY_S;
    endcase
    // Without the clear option the sequencer never leaves READY.
    if (INIT_CLEAR == 0) w_state_d = INIT_READY_S;
  end

  assign o_init_busy = (r_state == INIT_CLEAR_S);
  assign o_clr_ad    = r_cnt;

endmodule

// File: rtl/ram_be_pipe.sv
// ram_be_pipe: simple dual-port RAM with one byte-enabled write port and one read port
// with a 1- or 2-cycle pipelined read, optional read-during-write bypass and an optional
// post-reset clear sweep. Bit ordering is big-endian: byte 0 is the most significant byte.
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   o_init_busy     high while the clear sweep runs; all accesses are ignored
//   i_wrad, i_we    write address / strobe
//   i_wbe, i_d      byte enables (wbe[i] covers d[8*i +: 8]) / write data
//   i_rdad, i_re    read address / strobe
//   o_q, o_q_valid  read data (held between reads) / one-cycle valid pulse
module ram_be_pipe
  import ram_pkg::*;
#(
  parameter              RAM_OPT    = "m20k,no_rw_check",
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned ADDR_BITS  = $clog2(DEPTH),
  parameter int unsigned BE_BITS    = WIDTH / 8,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned RW_BYPASS  = 1,
  parameter int unsigned INIT_CLEAR = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  output logic                 o_init_busy,
  input  logic [0:ADDR_BITS-1] i_wrad,
  input  logic                 i_we,
  input  logic [0:BE_BITS-1]   i_wbe,
  input  logic [0:WIDTH-1]     i_d,
  input  logic [0:ADDR_BITS-1] i_rdad,
  input  logic                 i_re,
  output logic [0:WIDTH-1]     o_q,
  output logic                 o_q_valid
);

  if (WIDTH % BYTE_W != 0) begin : g_err_width
    $error("ram_be_pipe: WIDTH must be a multiple of 8");
  end
  if (RD_LATENCY < RD_LAT_MIN || RD_LATENCY > RD_LAT_MAX) begin : g_err_lat
    $error("ram_be_pipe: RD_LATENCY must be 1 or 2");
  end
  if (RAM_OPT == "") begin : g_err_opt
    $error("ram_be_pipe: RAM_OPT must not be empty");
  end

  localparam logic [ADDR_BITS:0] DEPTH_W = (ADDR_BITS + 1)'(DEPTH);

`ifdef use_altera_atts
  (* ramstyle = RAM_OPT *) logic [0:WIDTH-1] r_mem [DEPTH];
`else
  logic [0:WIDTH-1] r_mem [DEPTH];
`endif

  logic                 w_init_busy;
  logic                 w_clr_we;
  logic [0:ADDR_BITS-1] w_clr_ad;

  ram_init_seq #(
    .DEPTH      (DEPTH),
    .ADDR_BITS  (ADDR_BITS),
    .INIT_CLEAR (INIT_CLEAR)
  ) u_init_seq (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .o_init_busy (w_init_busy),
    .o_clr_we    (w_clr_we),
    .o_clr_ad    (w_clr_ad)
  );

  assign o_init_busy = w_init_busy;

  logic w_wr_acc;
  logic w_rd_acc;
  logic w_rd_in_range;
  logic w_coll;
  assign w_wr_acc      = i_we & ~w_init_busy & ({1'b0, i_wrad} < DEPTH_W);
  assign w_rd_acc      = i_re & ~w_init_busy;
  assign w_rd_in_range = ({1'b0, i_rdad} < DEPTH_W);
  assign w_coll        = w_wr_acc & w_rd_acc & (i_wrad == i_rdad);

  // Write mux: the clear sweep owns the port while busy (user writes are dropped then).
  logic                 w_wr_en;
  logic [0:ADDR_BITS-1] w_wr_ad;
  logic [0:WIDTH-1]     w_wr_d;
  logic [0:BE_BITS-1]   w_wr_be;

  always_comb begin
    w_wr_en = w_wr_acc;
    w_wr_ad = i_wrad;
    w_wr_d  = i_d;
    w_wr_be = i_wbe;
    if (w_init_busy) begin
      w_wr_en = w_clr_we;
      w_wr_ad = w_clr_ad;
      w_wr_d  = '0;
      w_wr_be = '1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      for (int i = 0; i < int'(BE_BITS); i++) begin
        if (w_wr_be[i]) r_mem[w_wr_ad][BYTE_W*i +: BYTE_W] <= w_wr_d[BYTE_W*i +: BYTE_W];
      end
    end
  end

  // Read word: out-of-range reads return zero; on a collision the bypass path returns
  // the word as it will look after this cycle's write.
  logic [0:WIDTH-1] w_old;
  logic [0:WIDTH-1] w_merge;
  logic [0:WIDTH-1] w_rd_word;

  assign w_old = w_rd_in_range ? r_mem[i_rdad] : '0;

  always_comb begin
    w_merge = w_old;
    for (int i = 0; i < int'(BE_BITS); i++) begin
      w_merge[BYTE_W*i +: BYTE_W] = be_merge(w_old[BYTE_W*i +: BYTE_W],
                                             i_d[BYTE_W*i +: BYTE_W], i_wbe[i]);
    end
  end

  assign w_rd_word = (RW_BYPASS != 0 && w_coll) ? w_merge : w_old;

  logic [0:WIDTH-1] r_s1;
  logic             r_s1_vld;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1     <= '0;
      r_s1_vld <= 1'b0;
    end else begin
      r_s1_vld <= w_rd_acc;
      if (w_rd_acc) r_s1 <= w_rd_word;
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic [0:WIDTH-1] r_s2;
    logic             r_s2_vld;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_s2     <= '0;
        r_s2_vld <= 1'b0;
      end else begin
        r_s2_vld <= r_s1_vld;
        if (r_s1_vld) r_s2 <= r_s1;
      end
    end

    assign o_q       = r_s2;
    assign o_q_valid = r_s2_vld;
  end else begin : g_lat1
    assign o_q       = r_s1;
    assign o_q_valid = r_s1_vld;
  end

endmodule

// File: tb/tb_ram_be_pipe.sv
module tb_ram_be_pipe;

  logic        clk;
  logic        rst_n;
  logic [0:4]  wrad;
  logic        we;
  logic [0:7]  wbe;
  logic [0:63] d;
  logic [0:4]  rdad;
  logic        re;

  // u0: defaults, u1: no bypass, u2: 2-cycle read, u3: DEPTH=24
  logic [0:63] q0, q1, q2, q3;
  logic        v0, v1, v2, v3;
  logic        b0, b1, b2, b3;

  int total = 0;
  int bad   = 0;

  ram_be_pipe u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .o_init_busy(b0), .i_wrad(wrad), .i_we(we), .i_wbe(wbe),
    .i_d(d), .i_rdad(rdad), .i_re(re), .o_q(q0), .o_q_valid(v0)
  );
  ram_be_pipe #(.RW_BYPASS(0)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .o_init_busy(b1), .i_wrad(wrad), .i_we(we), .i_wbe(wbe),
    .i_d(d), .i_rdad(rdad), .i_re(re), .o_q(q1), .o_q_valid(v1)
  );
  ram_be_pipe #(.RD_LATENCY(2)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .o_init_busy(b2), .i_wrad(wrad), .i_we(we), .i_wbe(wbe),
    .i_d(d), .i_rdad(rdad), .i_re(re), .o_q(q2), .o_q_valid(v2)
  );
  ram_be_pipe #(.DEPTH(24)) u_dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .o_init_busy(b3), .i_wrad(wrad), .i_we(we), .i_wbe(wbe),
    .i_d(d), .i_rdad(rdad), .i_re(re), .o_q(q3), .o_q_valid(v3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [0:4]  wrad;
    logic [0:7]  wbe;
    logic [0:63] d;
    logic        re;
    logic [0:4]  rdad;
    logic        exp_v;
    logic [0:63] exp_q;     // bypass instance
    logic [0:63] exp_q_nb;  // no-bypass instance
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [0:63] act, input logic [0:63] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic i_we, input logic [0:4] i_wrad, input logic [0:7] i_wbe,
                       input logic [0:63] i_d, input logic i_re, input logic [0:4] i_rdad);
    we   = i_we;
    wrad = i_wrad;
    wbe  = i_wbe;
    d    = i_d;
    re   = i_re;
    rdad = i_rdad;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 8'h00, 64'h0, 1'b0, 5'd0);
  endtask

  initial begin
    int busy0, busy3, pulses;
    logic done;
    logic [0:63] ones;
    ones = '1;

    tbl[0]  = '{1'b1, 5'd5,  8'hFF, 64'h0011223344556677, 1'b0, 5'd0,
                1'b0, 64'h0, 64'h0};
    tbl[1]  = '{1'b1, 5'd5,  8'h80, 64'hAAAAAAAAAAAAAAAA, 1'b0, 5'd0,
                1'b0, 64'h0, 64'h0};
    tbl[2]  = '{1'b0, 5'd0,  8'h00, 64'h0, 1'b1, 5'd5,
                1'b1, 64'hAA11223344556677, 64'hAA11223344556677};
    tbl[3]  = '{1'b1, 5'd3,  8'h0F, 64'h1234567890ABCDEF, 1'b1, 5'd3,
                1'b1, 64'h0000000090ABCDEF, 64'h0};
    tbl[4]  = '{1'b0, 5'd0,  8'h00, 64'h0, 1'b1, 5'd3,
                1'b1, 64'h0000000090ABCDEF, 64'h0000000090ABCDEF};
    tbl[5]  = '{1'b0, 5'd0,  8'h00, 64'h0, 1'b0, 5'd0,
                1'b0, 64'h0000000090ABCDEF, 64'h0000000090ABCDEF};
    tbl[6]  = '{1'b1, 5'd7,  8'h00, 64'hFFFFFFFFFFFFFFFF, 1'b0, 5'd0,
                1'b0, 64'h0000000090ABCDEF, 64'h0000000090ABCDEF};
    tbl[7]  = '{1'b0, 5'd0,  8'h00, 64'h0, 1'b1, 5'd7,
                1'b1, 64'h0, 64'h0};
    tbl[8]  = '{1'b1, 5'd7,  8'h3C, 64'h0102030405060708, 1'b1, 5'd7,
                1'b1, 64'h0000030405060000, 64'h0};
    tbl[9]  = '{1'b0, 5'd0,  8'h00, 64'h0, 1'b1, 5'd7,
                1'b1, 64'h0000030405060000, 64'h0000030405060000};
    tbl[10] = '{1'b1, 5'd31, 8'hFF, 64'hFFFFFFFFFFFFFFFF, 1'b1, 5'd5,
                1'b1, 64'hAA11223344556677, 64'hAA11223344556677};
    tbl[11] = '{1'b0, 5'd0,  8'h00, 64'h0, 1'b1, 5'd31,
                1'b1, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF};
    tbl[12] = '{1'b0, 5'd0,  8'h00, 64'h0, 1'b1, 5'd3,
                1'b1, 64'h0000000090ABCDEF, 64'h0000000090ABCDEF};

    // Reset state
    idle();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst q0", q0, 64'h0);
    chk("rst v0", 64'(v0), 64'h0);
    chk("rst busy0", 64'(b0), 64'h1);
    chk("rst v2", 64'(v2), 64'h0);
    chk("rst q2", q2, 64'h0);
    chk("rst busy3", 64'(b3), 64'h1);

    // Init sweep length
    rst_n = 1'b1;
    #1;
    busy0 = 0;
    busy3 = 0;
    for (int k = 0; k < 40; k++) begin
      if (b0) busy0++;
      if (b3) busy3++;
      @(negedge clk);
    end
    chk("init busy cycles d32", 64'(busy0), 64'd32);
    chk("init busy cycles d24", 64'(busy3), 64'd24);
    chk("ready busy1", 64'(b1), 64'h0);

    // Read back cleared array
    pulses = 0;
    for (int k = 0; k < 32; k++) begin
      drive(1'b0, 5'd0, 8'h00, 64'h0, 1'b1, 5'(k));
      @(negedge clk);
      if (v0) pulses++;
      chk($sformatf("clear data a%0d", k), q0, 64'h0);
    end
    idle();
    @(negedge clk);
    if (v0) pulses++;
    chk("clear read pulses", 64'(pulses), 64'd32);

    // Byte enables and collisions
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].we, tbl[i].wrad, tbl[i].wbe, tbl[i].d, tbl[i].re, tbl[i].rdad);
      @(negedge clk);
      chk($sformatf("vec%0d v", i), 64'(v0), 64'(tbl[i].exp_v));
      chk($sformatf("vec%0d q", i), q0, tbl[i].exp_q);
      chk($sformatf("vec%0d v nb", i), 64'(v1), 64'(tbl[i].exp_v));
      chk($sformatf("vec%0d q nb", i), q1, tbl[i].exp_q_nb);
    end

    // Two-cycle read pipeline, back-to-back
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 5'(k), 8'hFF, 64'(k), 1'b0, 5'd0);
      @(negedge clk);
    end
    idle();
    repeat (3) @(negedge clk);
    for (int j = 0; j < 7; j++) begin
      if (j < 4) drive(1'b0, 5'd0, 8'h00, 64'h0, 1'b1, 5'(j));
      else       idle();
      @(negedge clk);
      chk($sformatf("lat2 v j%0d", j), 64'(v2), (j >= 1 && j <= 4) ? 64'h1 : 64'h0);
      if (j >= 1) chk($sformatf("lat2 q j%0d", j), q2, (j <= 4) ? 64'(j - 1) : 64'd3);
      chk($sformatf("lat1 v j%0d", j), 64'(v0), (j < 4) ? 64'h1 : 64'h0);
      if (j < 4) chk($sformatf("lat1 q j%0d", j), q0, 64'(j));
    end

    // DEPTH=24 out-of-range handling
    drive(1'b1, 5'd30, 8'hFF, ones, 1'b0, 5'd0);
    @(negedge clk);
    drive(1'b0, 5'd0, 8'h00, 64'h0, 1'b1, 5'd30);
    @(negedge clk);
    chk("d24 oor v", 64'(v3), 64'h1);
    chk("d24 oor q", q3, 64'h0);
    chk("d32 a30 q", q0, ones);
    drive(1'b1, 5'd23, 8'hFF, 64'h0123456789ABCDEF, 1'b0, 5'd0);
    @(negedge clk);
    drive(1'b0, 5'd0, 8'h00, 64'h0, 1'b1, 5'd23);
    @(negedge clk);
    chk("d24 a23 v", 64'(v3), 64'h1);
    chk("d24 a23 q", q3, 64'h0123456789ABCDEF);
    idle();
    @(negedge clk);

    // Asynchronous reset clears outputs at once
    drive(1'b0, 5'd0, 8'h00, 64'h0, 1'b1, 5'd5);
    @(negedge clk);
    chk("pre-rst v", 64'(v0), 64'h1);
    chk("pre-rst q", q0, 64'hAA11223344556677);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst v", 64'(v0), 64'h0);
    chk("async rst q", q0, 64'h0);
    chk("async rst busy", 64'(b0), 64'h1);
    idle();
    @(negedge clk);

    // Reset dropped mid-sweep restarts it; accesses during the sweep are ignored
    rst_n = 1'b1;
    pulses = 0;
    busy0  = 0;
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 5'd31, 8'hFF, ones, 1'b1, 5'd31);
      @(negedge clk);
      if (v0) pulses++;
      if (b0) busy0++;
    end
    chk("sweep1 pulses", 64'(pulses), 64'h0);
    chk("sweep1 busy", 64'(busy0), 64'd10);
    rst_n = 1'b0;
    #1 chk("midclear rst v", 64'(v0), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    pulses = 0;
    busy0  = 0;
    done   = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (v0) pulses++;
      if (b0) busy0++;
      else if (!done) begin
        idle();
        done = 1'b1;
      end
      @(negedge clk);
    end
    chk("sweep2 busy cycles", 64'(busy0), 64'd32);
    chk("sweep2 pulses", 64'(pulses), 64'h0);
    drive(1'b0, 5'd0, 8'h00, 64'h0, 1'b1, 5'd31);
    @(negedge clk);
    chk("post-clear a31 v", 64'(v0), 64'h1);
    chk("post-clear a31 q", q0, 64'h0);
    drive(1'b0, 5'd0, 8'h00, 64'h0, 1'b1, 5'd5);
    @(negedge clk);
    chk("post-clear a5 q", q0, 64'h0);
    idle();
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
